// File: rtl/btn_event_gen_if.sv
// Event output port: valid/ready stream of {code, button index}.
interface btn_event_gen_if #(
  parameter int IDX_WIDTH = 2
);
  logic                 EVT_VALID_O;
  logic                 EVT_READY_I;
  logic [1:0]           EVT_CODE_O;
  logic [IDX_WIDTH-1:0] EVT_IDX_O;

  modport master (output EVT_VALID_O, EVT_CODE_O, EVT_IDX_O, input EVT_READY_I);
  modport slave  (input EVT_VALID_O, EVT_CODE_O, EVT_IDX_O, output EVT_READY_I);
endinterface

// File: rtl/btn_event_gen.sv
// Button event generator: per-button press/release/long/repeat FSMs with a
// one-entry pending slot each, fixed-priority merge into an event FIFO.

// One button: IDLE/PRESSED/HELD FSM, hold counter and pending event slot.
module btn_event_lane #(
  parameter int unsigned LONG_CLOCKS   = 32'd16777216,
  parameter int unsigned REPEAT_CLOCKS = 32'd4194304
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       btn_i,
  input  logic       drain_i,
  output logic       busy_o,
  output logic       slot_vld_o,
  output logic [1:0] slot_code_o,
  output logic       drop_o
);
  localparam logic [1:0]  EV_PRESS   = 2'b00;
  localparam logic [1:0]  EV_RELEASE = 2'b01;
  localparam logic [1:0]  EV_LONG    = 2'b10;
  localparam logic [1:0]  EV_REPEAT  = 2'b11;
  localparam logic [31:0] LONG_LAST  = 32'(LONG_CLOCKS - 1);
  localparam logic [31:0] REP_LAST   = 32'(REPEAT_CLOCKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, HELD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        slot_vld_q, slot_vld_d;
  logic [1:0]  slot_code_q, slot_code_d;
  logic        ev_emit;
  logic [1:0]  ev_code;

  // Next state, event emission and pending-slot update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ev_emit     = 1'b0;
    ev_code     = EV_PRESS;
    slot_vld_d  = slot_vld_q && !drain_i;
    slot_code_d = slot_code_q;
    drop_o      = 1'b0;
    case (state_q)
      IDLE: if (btn_i) begin
        state_d = PRESSED; cnt_d = '0; ev_emit = 1'b1; ev_code = EV_PRESS;
      end
      PRESSED: begin
        // release takes priority over the LONG threshold
        if (!btn_i) begin
          state_d = IDLE; ev_emit = 1'b1; ev_code = EV_RELEASE;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HELD; cnt_d = '0; ev_emit = 1'b1; ev_code = EV_LONG;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HELD: begin
        if (!btn_i) begin
          state_d = IDLE; ev_emit = 1'b1; ev_code = EV_RELEASE;
        end else if (cnt_q == REP_LAST) begin
          cnt_d = '0; ev_emit = 1'b1; ev_code = EV_REPEAT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // a slot drained at this edge can take the new event
    if (ev_emit) begin
      if (!slot_vld_q || drain_i) begin
        slot_vld_d  = 1'b1;
        slot_code_d = ev_code;
      end else begin
        drop_o = 1'b1;
      end
    end
  end

  // State, counter and slot registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      slot_vld_q  <= 1'b0;
      slot_code_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_vld_q  <= slot_vld_d;
      slot_code_q <= slot_code_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign slot_vld_o  = slot_vld_q;
  assign slot_code_o = slot_code_q;
endmodule

module btn_event_gen #(
  parameter int          PORT_WIDTH    = 4,
  parameter int          IDX_WIDTH     = 2,
  parameter int unsigned LONG_CLOCKS   = 32'd16777216,
  parameter int unsigned REPEAT_CLOCKS = 32'd4194304,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic                  CLK_I,
  input  logic                  RST_N_I,
  input  logic [PORT_WIDTH-1:0] BTN_I,
  output logic [PORT_WIDTH-1:0] BTN_STATE_O,
  output logic                  OVF_O,
  btn_event_gen_if.master       evt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 + IDX_WIDTH;

  logic [PORT_WIDTH-1:0]      slot_vld, drain, drop;
  logic [PORT_WIDTH-1:0][1:0] slot_code;

  for (genvar g = 0; g < PORT_WIDTH; g++) begin : g_lane
    btn_event_lane #(
      .LONG_CLOCKS  (LONG_CLOCKS),
      .REPEAT_CLOCKS(REPEAT_CLOCKS)
    ) u_lane (
      .clk_i      (CLK_I),
      .rst_n_i    (RST_N_I),
      .btn_i      (BTN_I[g]),
      .drain_i    (drain[g]),
      .busy_o     (BTN_STATE_O[g]),
      .slot_vld_o (slot_vld[g]),
      .slot_code_o(slot_code[g]),
      .drop_o     (drop[g])
    );
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q;
  logic          ovf_q;
  logic          full, found, wr_en, pop, vld;
  logic [EW-1:0] wr_data, head;

  assign full = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign vld  = (fill_q != '0);
  assign pop  = vld && evt.EVT_READY_I;

  // Lowest-index occupied slot wins; it drains only when the FIFO takes it.
  always_comb begin
    drain   = '0;
    found   = 1'b0;
    wr_data = '0;
    for (int i = 0; i < PORT_WIDTH; i++) begin
      if (slot_vld[i] && !found) begin
        found    = 1'b1;
        wr_data  = {slot_code[i], IDX_WIDTH'(i)};
        drain[i] = !full;
      end
    end
    wr_en = found && !full;
  end

  // Event storage; contents are only meaningful below the fill level.
  always_ff @(posedge CLK_I) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   fill_q <= fill_q + (AW+1)'(1);
        2'b01:   fill_q <= fill_q - (AW+1)'(1);
        default: fill_q <= fill_q;
      endcase
      ovf_q <= ovf_q | (|drop);
    end
  end

  // Head fields read as zero while the FIFO is empty.
  assign head            = mem_q[rd_ptr_q];
  assign evt.EVT_VALID_O = vld;
  assign evt.EVT_CODE_O  = vld ? head[EW-1:IDX_WIDTH] : 2'b00;
  assign evt.EVT_IDX_O   = vld ? head[IDX_WIDTH-1:0] : '0;
  assign OVF_O           = ovf_q;
endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen with short hold/repeat thresholds.
module tb_btn_event_gen;
  localparam int PW = 4;
  localparam int IW = 2;
  localparam logic [1:0] P = 2'b00, R = 2'b01, L = 2'b10, RP = 2'b11;

  logic          CLK_I = 1'b0;
  logic          RST_N_I;
  logic [PW-1:0] BTN_I;
  logic [PW-1:0] BTN_STATE_O;
  logic          OVF_O;

  btn_event_gen_if #(.IDX_WIDTH(IW)) evt_if ();

  btn_event_gen #(
    .PORT_WIDTH(PW), .IDX_WIDTH(IW), .LONG_CLOCKS(8), .REPEAT_CLOCKS(4), .FIFO_DEPTH(4)
  ) dut (
    .CLK_I      (CLK_I),
    .RST_N_I    (RST_N_I),
    .BTN_I      (BTN_I),
    .BTN_STATE_O(BTN_STATE_O),
    .OVF_O      (OVF_O),
    .evt        (evt_if)
  );

  always #5 CLK_I = ~CLK_I;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [3:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge CLK_I);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic push(input logic [1:0] code, input logic [1:0] idx);
    sb_q.push_back({code, idx});
  endtask

  wire [3:0] evt_w = {evt_if.EVT_CODE_O, evt_if.EVT_IDX_O};

  // Pop/compare on every handshake; hold-stability while stalled.
  logic       hold = 1'b0;
  logic [3:0] hold_evt;
  always @(negedge CLK_I) begin
    if (RST_N_I !== 1'b1) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_vld", 32'(evt_if.EVT_VALID_O), 32'd1);
        chk("stall_evt", 32'(evt_w), 32'(hold_evt));
      end
      if (evt_if.EVT_VALID_O && evt_if.EVT_READY_I) begin
        if (sb_q.size() == 0) chk("sb_extra_evt", 32'(evt_w), 32'hFFFF_FFFF);
        else chk("evt", 32'(evt_w), 32'(sb_q.pop_front()));
      end
      hold     = evt_if.EVT_VALID_O && !evt_if.EVT_READY_I;
      hold_evt = evt_w;
    end
  end

  initial begin
    RST_N_I = 1'b0;
    BTN_I   = '0;
    evt_if.EVT_READY_I = 1'b1;
    tick();
    chk("rst_vld",   32'(evt_if.EVT_VALID_O), 32'd0);
    chk("rst_evt",   32'(evt_w), 32'd0);
    chk("rst_state", 32'(BTN_STATE_O), 32'd0);
    chk("rst_ovf",   32'(OVF_O), 32'd0);
    tick(); tick();
    RST_N_I = 1'b1;
    cyc = 0;

    // short press on button 0
    run_to(9); BTN_I[0] = 1'b1; push(P, 2'd0);
    tick();
    chk("sp_nobypass", 32'(evt_if.EVT_VALID_O), 32'd0);
    chk("sp_state",    32'(BTN_STATE_O), 32'b0001);
    tick();
    chk("sp_press_vld", 32'(evt_if.EVT_VALID_O), 32'd1);
    chk("sp_press_evt", 32'(evt_w), 32'({P, 2'd0}));
    run_to(12); BTN_I[0] = 1'b0; push(R, 2'd0);
    tick();
    chk("sp_rel_lat", 32'(evt_if.EVT_VALID_O), 32'd0);
    chk("sp_state0",  32'(BTN_STATE_O), 32'd0);
    tick();
    chk("sp_rel_evt", 32'(evt_w), 32'({R, 2'd0}));

    // long hold on button 2: PRESS, LONG, REPEAT x2, RELEASE
    run_to(39); BTN_I[2] = 1'b1;
    push(P, 2'd2); push(L, 2'd2); push(RP, 2'd2); push(RP, 2'd2); push(R, 2'd2);
    run_to(48);
    chk("lh_state_t8", 32'(BTN_STATE_O[2]), 32'd1);
    chk("lh_long_lat", 32'(evt_if.EVT_VALID_O), 32'd0);
    tick();
    chk("lh_long_evt", 32'(evt_w), 32'({L, 2'd2}));
    run_to(59);
    chk("lh_state_t19", 32'(BTN_STATE_O[2]), 32'd1);
    BTN_I[2] = 1'b0;
    tick();
    chk("lh_state_t20", 32'(BTN_STATE_O[2]), 32'd0);

    // release exactly at the LONG threshold on button 1
    run_to(79); BTN_I[1] = 1'b1; push(P, 2'd1); push(R, 2'd1);
    run_to(87); BTN_I[1] = 1'b0;
    tick();
    chk("th_state", 32'(BTN_STATE_O[1]), 32'd0);
    tick();
    chk("th_rel_evt", 32'(evt_w), 32'({R, 2'd1}));

    // all four pressed at once: drained in index order, one per cycle
    run_to(109); BTN_I = 4'hF;
    for (int k = 0; k < PW; k++) push(P, 2'(k));
    tick();
    for (int k = 0; k < PW; k++) begin
      tick();
      chk("sim_order", 32'(evt_w), 32'({P, 2'(k)}));
    end
    run_to(115); BTN_I = 4'h0;
    for (int k = 0; k < PW; k++) push(R, 2'(k));
    run_to(130);
    chk("sim_ovf", 32'(OVF_O), 32'd0);

    // overflow with a stalled consumer on button 0
    run_to(139); evt_if.EVT_READY_I = 1'b0; BTN_I[0] = 1'b1;
    push(P, 2'd0); push(L, 2'd0); push(RP, 2'd0); push(RP, 2'd0); push(RP, 2'd0); push(R, 2'd0);
    run_to(163);
    chk("ovf_before", 32'(OVF_O), 32'd0);
    tick();
    chk("ovf_set", 32'(OVF_O), 32'd1);
    run_to(168); evt_if.EVT_READY_I = 1'b1;
    tick();      BTN_I[0] = 1'b0;
    run_to(190);
    chk("ovf_sticky", 32'(OVF_O), 32'd1);

    // reset with two queued events and button 1 held
    run_to(199); evt_if.EVT_READY_I = 1'b0; BTN_I[1] = 1'b1; BTN_I[3] = 1'b1;
    run_to(202);
    chk("rm_pre_vld", 32'(evt_if.EVT_VALID_O), 32'd1);
    RST_N_I = 1'b0; BTN_I[3] = 1'b0;
    tick();
    chk("rm_vld",   32'(evt_if.EVT_VALID_O), 32'd0);
    chk("rm_ovf",   32'(OVF_O), 32'd0);
    chk("rm_state", 32'(BTN_STATE_O), 32'd0);
    chk("rm_evt",   32'(evt_w), 32'd0);
    tick();
    RST_N_I = 1'b1; push(P, 2'd1);
    tick();
    chk("rm_post_state", 32'(BTN_STATE_O), 32'b0010);
    chk("rm_post_lat",   32'(evt_if.EVT_VALID_O), 32'd0);
    evt_if.EVT_READY_I = 1'b1;
    tick();
    chk("rm_post_evt", 32'(evt_w), 32'({P, 2'd1}));
    run_to(210); BTN_I[1] = 1'b0; push(R, 2'd1);
    run_to(225);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("end_ovf",  32'(OVF_O), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
